window_gen: RTL and testbench

Raster-to-window generator feeding the intensity/edge-detect datapath. Accepts 24 bpp pixels one per handshake in raster order and emits, for each interior pixel, the 216-bit 3x3 neighbourhood frame consumed by `intensity.pixelData`. Two internal line buffers and a 3x3 shift window replace the bench-side frame assembly. Output uses a one-entry valid/ready register with back-pressure.

---
 rtl/cartoon_pkg.sv | 11 +
 rtl/line_buffer.sv | 25 ++
 rtl/window_gen.sv | 137 +++++++++++++
 tb/tb_window_gen.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cartoon_pkg.sv
// Shared pixel and frame definitions for the cartoon filter datapath.
// A frame is nine pixels packed MSB-first, with slot 1 (top-left) at index 8.
package cartoon_pkg;

    localparam int PIX_W   = 24;
    localparam int FRAME_W = 9 * PIX_W;

    typedef logic [2:0][7:0]       pixel_t;
    typedef logic [8:0][PIX_W-1:0] frame_t;

endpackage

// File: rtl/line_buffer.sv
// One raster line of pixels.
// The read is combinational, so a read and a write to the same address return the old word.
module line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage arrays carry no reset; every word is written before it can reach an output.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/window_gen.sv
// Raster-to-3x3-window generator: two line buffers feed a column shift window.
// A one-entry valid/ready output register provides back-pressure.
module window_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int PIX_W      = cartoon_pkg::PIX_W
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic [PIX_W-1:0]              in_pixel,
    input  logic                          in_sof,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [9*PIX_W-1:0]            pixelFrame,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(IMG_WIDTH)-1:0]  center_col,
    output logic [$clog2(IMG_HEIGHT)-1:0] center_row,
    output logic                          frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    // Index 2 is row r-2, index 0 is row r.
    typedef logic [2:0][PIX_W-1:0] column_t;

    logic [CW-1:0]            col_q, col_d, pos_col;
    logic [RW-1:0]            row_q, row_d, pos_row;
    logic                     accept, emit, last_col, last_row;
    logic [PIX_W-1:0]         lb0_rd, lb1_rd;
    column_t                  new_col;
    logic [1:0][2:0][PIX_W-1:0] win_q;  // [1] = column c-1, [0] = column c-2

    logic [8:0][PIX_W-1:0]    frame_q, frame_d;
    logic                     out_valid_q, out_valid_d;
    logic [CW-1:0]            ccol_q, ccol_d;
    logic [RW-1:0]            crow_q, crow_d;
    logic                     done_q, done_d;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // An accepted start-of-image pixel is (0,0) regardless of where the counters stand.
    assign pos_col  = in_sof ? '0 : col_q;
    assign pos_row  = in_sof ? '0 : row_q;
    assign last_col = (pos_col == COL_LAST);
    assign last_row = (pos_row == ROW_LAST);
    assign emit     = accept && (pos_row >= RW'(2)) && (pos_col >= CW'(2));
    assign new_col  = {lb1_rd, lb0_rd, in_pixel};

    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb0 (
        .clk   (clk),
        .we    (accept),
        .addr  (pos_col),
        .wdata (in_pixel),
        .rdata (lb0_rd)
    );

    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb1 (
        .clk   (clk),
        .we    (accept),
        .addr  (pos_col),
        .wdata (lb0_rd),
        .rdata (lb1_rd)
    );

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        col_d       = col_q;
        row_d       = row_q;
        done_d      = 1'b0;
        frame_d     = frame_q;
        ccol_d      = ccol_q;
        crow_d      = crow_q;
        out_valid_d = out_valid_q;

        if (accept) begin
            if (last_col) begin
                col_d  = '0;
                row_d  = last_row ? '0 : pos_row + 1'b1;
                done_d = last_row;
            end else begin
                col_d  = pos_col + 1'b1;
                row_d  = pos_row;
            end
        end

        if (emit) begin
            frame_d     = {win_q[0][2], win_q[1][2], new_col[2],
                           win_q[0][1], win_q[1][1], new_col[1],
                           win_q[0][0], win_q[1][0], new_col[0]};
            ccol_d      = pos_col - 1'b1;
            crow_d      = pos_row - 1'b1;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            col_q       <= '0;
            row_q       <= '0;
            done_q      <= 1'b0;
            frame_q     <= '0;
            ccol_q      <= '0;
            crow_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            done_q      <= done_d;
            frame_q     <= frame_d;
            ccol_q      <= ccol_d;
            crow_q      <= crow_d;
            out_valid_q <= out_valid_d;
        end
    end

    // The window only matters once r>=2 and c>=2, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            win_q <= {new_col, win_q[1]};
        end
    end

    assign pixelFrame = frame_q;
    assign out_valid  = out_valid_q;
    assign center_col = ccol_q;
    assign center_row = crow_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_window_gen.sv
// Directed bench for window_gen on a 4x4 image with a scoreboard of expected frames.
// Expected frames are built from a bench-side copy of the image.
module tb_window_gen;
    import cartoon_pkg::*;

    localparam int W = 4;
    localparam int H = 4;

    logic                 clk = 1'b0;
    logic                 n_rst;
    logic [PIX_W-1:0]     in_pixel;
    logic                 in_sof, in_valid, in_ready;
    logic [FRAME_W-1:0]   pixelFrame;
    logic                 out_valid, out_ready;
    logic [1:0]           center_col, center_row;
    logic                 frame_done;

    window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PIX_W)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .in_pixel   (in_pixel),
        .in_sof     (in_sof),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .pixelFrame (pixelFrame),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .center_col (center_col),
        .center_row (center_row),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        frame_t f;
        int     r;
        int     c;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    exp_t        sb[$];
    frame_t      got_q[$];
    frame_t      ref_q[$];
    int          pop_cyc[$];
    logic [PIX_W-1:0] img [H][W];
    int          m_r = 0;
    int          m_c = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [FRAME_W-1:0] got, input logic [FRAME_W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic frame_t mk(input int r, input int c);
        frame_t f;
        for (int s = 0; s < 9; s++) f[8-s] = img[r-2+s/3][c-2+s%3];
        return f;
    endfunction

    task automatic model_accept(input logic [PIX_W-1:0] pix, input logic sof);
        exp_t e;
        if (sof) begin
            m_r = 0;
            m_c = 0;
        end
        img[m_r][m_c] = pix;
        if (m_r >= 2 && m_c >= 2) begin
            e.f = mk(m_r, m_c);
            e.r = m_r - 1;
            e.c = m_c - 1;
            sb.push_back(e);
        end
        if (m_c == W - 1) begin
            m_c = 0;
            m_r = (m_r == H - 1) ? 0 : m_r + 1;
        end else begin
            m_c++;
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_pixel(input logic [PIX_W-1:0] pix, input logic sof);
        int waits = 0;
        in_pixel = pix;
        in_sof   = sof;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        check("accept_timeout", FRAME_W'(in_ready), 1);
        if (in_ready) begin
            model_accept(pix, sof);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_range(input int base, input int lo, input int hi, input logic sof, input logic gap);
        for (int i = lo; i <= hi; i++) begin
            send_pixel(PIX_W'(base + 16 * (i / W) + (i % W)), sof && (i == lo));
            if (gap && (i % 5 == 4)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic clear_obs();
        got_q.delete();
        pop_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Output monitor: pops the scoreboard on every consumed frame.
    always @(negedge clk) begin
        if (n_rst === 1'b1) begin
            if (frame_done) done_cnt++;
            if (out_valid && out_ready) begin
                check("sb_nonempty", FRAME_W'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("frame", pixelFrame, e.f);
                    check("center_row", FRAME_W'(center_row), FRAME_W'(e.r));
                    check("center_col", FRAME_W'(center_col), FRAME_W'(e.c));
                    got_q.push_back(frame_t'(pixelFrame));
                    pop_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        frame_t first;
        int     t0;
        first = {24'h00, 24'h01, 24'h02, 24'h10, 24'h11, 24'h12, 24'h20, 24'h21, 24'h22};

        n_rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0; out_ready = 1'b1;
        #2;
        check("rst_in_ready", FRAME_W'(in_ready), 1);
        check("rst_out_valid", FRAME_W'(out_valid), 0);
        check("rst_frame", pixelFrame, 0);
        check("rst_center", FRAME_W'({center_row, center_col}), 0);
        check("rst_frame_done", FRAME_W'(frame_done), 0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(posedge clk); #1;

        // Basic image
        clear_obs();
        send_range(0, 0, 15, 1'b0, 1'b0);
        @(negedge clk);
        check("done_pulse", FRAME_W'(frame_done), 1);
        @(negedge clk);
        check("done_single", FRAME_W'(frame_done), 0);
        drain();
        check("basic_count", FRAME_W'(got_q.size()), 4);
        check("basic_first", got_q[0], first);
        check("basic_done_cnt", FRAME_W'(done_cnt), 1);
        ref_q = got_q;

        // Back-pressure on the first frame
        clear_obs();
        out_ready = 1'b0;
        send_range(0, 0, 10, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_in_ready", FRAME_W'(in_ready), 0);
            check("stall_valid", FRAME_W'(out_valid), 1);
            check("stall_frame", pixelFrame, first);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send_range(0, 11, 15, 1'b0, 1'b0);
        drain();
        check("bp_count", FRAME_W'(got_q.size()), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) check("bp_seq", got_q[i], ref_q[i]);
        check("bp_done_cnt", FRAME_W'(done_cnt), 1);

        // Throughput
        clear_obs();
        t0 = cyc;
        send_range(0, 0, 15, 1'b0, 1'b0);
        check("tp_cycles", FRAME_W'(cyc - t0), 16);
        drain();
        check("tp_count", FRAME_W'(got_q.size()), 4);
        if (pop_cyc.size() >= 2) check("tp_consecutive", FRAME_W'(pop_cyc[1] - pop_cyc[0]), 1);

        // Mid-image resync
        clear_obs();
        send_range(0, 0, 5, 1'b0, 1'b0);
        send_range(32'h100, 0, 15, 1'b1, 1'b0);
        drain();
        check("resync_count", FRAME_W'(got_q.size()), 4);
        if (got_q.size() > 0) check("resync_slot1", FRAME_W'(got_q[0][8]), 24'h100);
        check("resync_done_cnt", FRAME_W'(done_cnt), 1);

        // Asynchronous reset with a frame pending
        clear_obs();
        out_ready = 1'b0;
        send_range(0, 0, 10, 1'b0, 1'b0);
        check("pre_rst_valid", FRAME_W'(out_valid), 1);
        n_rst = 1'b0;
        #1;
        check("arst_out_valid", FRAME_W'(out_valid), 0);
        check("arst_in_ready", FRAME_W'(in_ready), 1);
        check("arst_frame", pixelFrame, 0);
        n_rst = 1'b1;
        sb.delete();
        m_r = 0;
        m_c = 0;
        out_ready = 1'b1;
        send_range(0, 0, 15, 1'b0, 1'b0);
        drain();
        check("arst_count", FRAME_W'(got_q.size()), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) check("arst_match", got_q[i], ref_q[i]);

        // Back-to-back images, with idle gaps in the first
        clear_obs();
        send_range(32'h200, 0, 15, 1'b0, 1'b1);
        send_range(32'h300, 0, 15, 1'b0, 1'b0);
        drain();
        check("b2b_count", FRAME_W'(got_q.size()), 8);
        if (got_q.size() > 4) check("b2b_second_slot1", FRAME_W'(got_q[4][8]), 24'h300);
        check("b2b_done_cnt", FRAME_W'(done_cnt), 2);
        check("sb_empty_end", FRAME_W'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
